// File: rtl/ccff_readback.sv
// Configuration-chain readback: shifts the chain CHAIN_LEN times, packs tail bits
// LSB-first into WORD_W-bit words and hands them out over valid/ready.
module ccff_readback #(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                               prog_clk,
  input  logic                               pReset_n,
  input  logic                               start,
  input  logic                               ccff_tail,
  output logic                               ccff_shift_en,
  output logic                               ccff_loop,
  output logic [WORD_W-1:0]                  word_data,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(CHAIN_LEN+1)-1:0]     bit_count
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLUSH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              pend_q, pend_d;
  logic              shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] acc_cap;
  logic [CW-1:0]     cnt_inc;
  logic              word_end;
  logic              out_free;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // A completed word waits in acc_q (pend_q) while the output register is still full.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    data_d   = data_q;
    valid_d  = valid_q && !word_ready;
    pend_d   = pend_q;
    shift_d  = shift_q;
    out_free = !valid_q || word_ready;
    cnt_inc  = cnt_q + CW'(1);
    acc_cap  = acc_q;
    acc_cap[idx_q] = ccff_tail;
    word_end = (idx_q == IW'(WORD_W - 1)) || (cnt_inc == CW'(CHAIN_LEN));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          idx_d   = '0;
          acc_d   = '0;
          pend_d  = 1'b0;
          shift_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (shift_q) begin
          cnt_d = cnt_inc;
          idx_d = word_end ? '0 : idx_q + IW'(1);
          if (word_end && out_free) begin
            data_d  = acc_cap;
            valid_d = 1'b1;
            acc_d   = '0;
            shift_d = (cnt_inc != CW'(CHAIN_LEN));
          end else if (word_end) begin
            acc_d   = acc_cap;
            pend_d  = 1'b1;
            shift_d = 1'b0;
          end else begin
            acc_d   = acc_cap;
          end
        end else if (pend_q) begin
          if (out_free) begin
            data_d  = acc_q;
            valid_d = 1'b1;
            acc_d   = '0;
            pend_d  = 1'b0;
            shift_d = (cnt_q != CW'(CHAIN_LEN));
          end
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (out_free) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign ccff_loop     = ccff_tail;
  assign ccff_shift_en = shift_q;
  assign word_data     = data_q;
  assign word_valid    = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bit_count     = cnt_q;

endmodule

// File: tb/tb_ccff_readback.sv
// Scoreboard bench for ccff_readback: a bit-level chain model feeds the tail, expected
// words come from a snapshot of the chain, and a negedge monitor checks every output.
module tb_ccff_readback;
  localparam int unsigned L  = 20;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = (L + W - 1) / W;
  localparam int unsigned CW = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          pReset_n;
  logic          start;
  logic          ccff_tail;
  logic          ccff_shift_en;
  logic          ccff_loop;
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic          word_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;

  ccff_readback #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk      (clk),
    .pReset_n      (pReset_n),
    .start         (start),
    .ccff_tail     (ccff_tail),
    .ccff_shift_en (ccff_shift_en),
    .ccff_loop     (ccff_loop),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count)
  );

  always #5 clk = ~clk;

  // Chain model: chain[0] is the tail flop; a shift moves everything one step toward it.
  logic [L-1:0] chain = L'(64'h0000_0000_000A_5C3B);
  logic [L-1:0] snap;
  logic         head_rnd = 1'b0;
  logic         loop_mode = 1'b0;
  int           total_shifts = 0;
  int           edge_ctr = 0;

  assign ccff_tail = chain[0];

  always @(posedge clk) begin
    edge_ctr <= edge_ctr + 1;
    if (ccff_shift_en) begin
      chain        <= {(loop_mode ? ccff_loop : head_rnd), chain[L-1:1]};
      total_shifts <= total_shifts + 1;
    end
  end

  // Stimulus-side state read by the monitor
  logic [W-1:0] exp_q[$];
  bit           active = 1'b0;
  bit           check_lat = 1'b0;
  bit           to_req = 1'b0;
  int           base_shifts = 0;
  int           base_pops = 0;
  int           start_edge = 0;

  // Monitor-side state
  int  checks = 0;
  int  errors = 0;
  int  total_pops = 0;
  int  done_seen = 0;
  bit  to_ack = 1'b0;
  int  m_capt, m_xfer, m_compl;
  bit  m_exp_se;

  always @(negedge clk) begin
    if (!pReset_n) begin
      checks++;
      if (ccff_shift_en || word_valid || busy || done || word_data != '0 || bit_count != '0) begin
        errors++;
        $display("FAIL reset_outputs: got se=%0b v=%0b busy=%0b done=%0b data=%h cnt=%0d, required all 0",
                 ccff_shift_en, word_valid, busy, done, word_data, bit_count);
      end
    end else begin
      // The chain may advance only while fewer than two completed words are untransferred.
      m_capt   = total_shifts - base_shifts;
      m_xfer   = total_pops - base_pops;
      m_compl  = (m_capt >= int'(L)) ? int'(NW) : m_capt / int'(W);
      m_exp_se = active && (m_capt < int'(L)) && ((m_compl - m_xfer) < 2);
      checks++;
      if (ccff_shift_en !== m_exp_se) begin
        errors++;
        $display("FAIL shift_en: got %0b required %0b (captured %0d, transferred %0d, edge %0d)",
                 ccff_shift_en, m_exp_se, m_capt, m_xfer, edge_ctr);
      end
      if (word_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h, required no valid word", word_data);
        end else if (word_data !== exp_q[0]) begin
          errors++;
          $display("FAIL word_data: got %h required %h", word_data, exp_q[0]);
        end
        if (word_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          total_pops++;
        end
      end
      if (done) begin
        checks++;
        if (bit_count != CW'(L) || m_capt != int'(L) || exp_q.size() != 0) begin
          errors++;
          $display("FAIL done_totals: got bit_count=%0d shifts=%0d words_left=%0d, required %0d %0d 0",
                   bit_count, m_capt, exp_q.size(), L, L);
        end
        if (check_lat) begin
          checks++;
          if (edge_ctr - start_edge != int'(L) + 2) begin
            errors++;
            $display("FAIL done_latency: got %0d edges after start, required %0d",
                     edge_ctr - start_edge, L + 2);
          end
        end
        if (loop_mode) begin
          checks++;
          if (chain !== snap) begin
            errors++;
            $display("FAIL loop_restore: got chain %h required %h", chain, snap);
          end
        end
        done_seen++;
      end
    end
    if (to_req && !to_ack) begin
      to_ack = 1'b1;
      checks++;
      errors++;
      $display("FAIL timeout: got no done pulse within 400 cycles, required one");
    end
  end

  // mode 0: ready=1; 1: random ready; 2: 12-cycle stall after first word; 3: ready=1 plus stray start
  task automatic do_run(input int mode, input bit lp, input int rst_at);
    int           c;
    int           seen0;
    bit           bp_started;
    int           bp_left;
    logic [W-1:0] w;
    @(posedge clk); #1;
    loop_mode = lp;
    check_lat = (mode == 0 || mode == 3);
    snap      = chain;
    for (int k = 0; k < int'(NW); k++) begin
      w = '0;
      for (int j = 0; j < int'(W); j++)
        if (k * int'(W) + j < int'(L)) w[j] = chain[k * int'(W) + j];
      exp_q.push_back(w);
    end
    seen0       = done_seen;
    base_shifts = total_shifts;
    base_pops   = total_pops;
    start       = 1'b1;
    word_ready  = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    active     = 1'b1;
    start_edge = edge_ctr;
    c          = 0;
    bp_started = 1'b0;
    bp_left    = 0;
    while (done_seen == seen0 && c < 400) begin
      head_rnd = 1'($urandom_range(0, 1));
      start    = (mode == 3 && c == 5);
      case (mode)
        1: word_ready = 1'($urandom_range(0, 1));
        2: begin
          if (word_valid && !bp_started) begin
            bp_started = 1'b1;
            bp_left    = 12;
          end
          word_ready = (bp_left == 0);
          if (bp_left > 0) bp_left--;
        end
        default: word_ready = 1'b1;
      endcase
      if (c == rst_at) begin
        pReset_n = 1'b0;
        exp_q.delete();
        active = 1'b0;
        @(posedge clk); #1;
        pReset_n = 1'b1;
        start    = 1'b0;
        return;
      end
      @(posedge clk); #1;
      c++;
    end
    if (done_seen == seen0) begin
      to_req = 1'b1;
      exp_q.delete();
    end
    start      = 1'b0;
    word_ready = 1'b1;
    active     = 1'b0;
  endtask

  initial begin
    pReset_n   = 1'b0;
    start      = 1'b0;
    word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 pReset_n = 1'b1;
    do_run(0, 1'b0, -1);
    do_run(2, 1'b0, -1);
    do_run(0, 1'b1, -1);
    do_run(0, 1'b1, -1);
    repeat (3) do_run(1, 1'b0, -1);
    do_run(0, 1'b0, 7);
    do_run(0, 1'b0, -1);
    do_run(3, 1'b0, -1);
    do_run(2, 1'b1, -1);
    do_run(1, 1'b1, -1);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
